// File: rtl/fft_16_4_out_serializer.sv
// Output serializer for the 16-point FFT: captures a full 16-sample frame in one cycle
// and streams it as four 4-sample valid/ready beats through an active + pending buffer pair.
`timescale 1ns/1ps

module fft_16_4_out_serializer #(
  parameter int OUTPUT_WIDTH = 16,
  parameter bit BIT_REVERSE  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_sync,
  input  logic                    i_valid,
  input  logic [OUTPUT_WIDTH-1:0] i_data [16][2],
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [OUTPUT_WIDTH-1:0] o_data [4][2],
  output logic [1:0]              o_beat_idx,
  output logic                    o_last,
  output logic                    o_overflow,
  input  logic                    clr_overflow
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       p_v_q, p_v_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  logic [OUTPUT_WIDTH-1:0] a_buf [16][2];
  logic [OUTPUT_WIDTH-1:0] p_buf [16][2];

  logic load_a_in;
  logic load_a_from_p;
  logic load_p;
  logic drop;
  logic fire;
  logic eof;

  // Output sample j of a frame comes from input index src_index(j).
  function automatic logic [3:0] src_index(input logic [3:0] j);
    return BIT_REVERSE ? {j[0], j[1], j[2], j[3]} : j;
  endfunction

  assign fire = (state_q == STREAM) && o_ready;
  assign eof  = fire && (cnt_q == 2'd3);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    p_v_d         = p_v_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    load_a_in     = 1'b0;
    load_a_from_p = 1'b0;
    load_p        = 1'b0;
    drop          = 1'b0;

    if (fire) begin
      cnt_d = cnt_q + 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          load_a_in = 1'b1;
          cnt_d     = 2'd0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (eof) begin
          cnt_d = 2'd0;
          if (p_v_q) begin
            // Pending frame is promoted; a frame arriving now refills pending without loss.
            load_a_from_p = 1'b1;
            if (i_valid) load_p = 1'b1;
            else         p_v_d  = 1'b0;
          end else if (i_valid) begin
            load_a_in = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (i_valid) begin
          if (!p_v_q) begin
            load_p = 1'b1;
            p_v_d  = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A drop in the same cycle as a clear must leave the flag set.
    if (clr_overflow) ovf_d = 1'b0;
    if (drop)         ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_sync) begin
      state_q <= IDLE;
      p_v_q   <= 1'b0;
      cnt_q   <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_v_q   <= p_v_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: the frame buffers carry no reset; their contents are only observable while a valid bit is set.
  always_ff @(posedge clk) begin
    if (load_a_in)          a_buf <= i_data;
    else if (load_a_from_p) a_buf <= p_buf;
    if (load_p)             p_buf <= i_data;
  end

  assign o_valid    = (state_q == STREAM);
  assign o_beat_idx = cnt_q;
  assign o_last     = o_valid && (cnt_q == 2'd3);
  assign o_overflow = ovf_q;

  always_comb begin
    logic [3:0] src;
    src = 4'd0;
    for (int l = 0; l < 4; l++) begin
      src = src_index({cnt_q, l[1:0]});
      for (int c = 0; c < 2; c++) begin
        o_data[l][c] = o_valid ? a_buf[src][c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_16_4_out_serializer.sv
// Bench for fft_16_4_out_serializer: natural-order and bit-reversed instances share stimulus
// and are checked against a frame-queue reference model, fixed vectors and corner sequences.
`timescale 1ns/1ps

module tb_fft_16_4_out_serializer;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_sync, i_valid, o_ready, clr_overflow;
  logic [W-1:0] i_data [16][2];

  logic         n_valid, n_last, n_ovf;
  logic [1:0]   n_idx;
  logic [W-1:0] n_data [4][2];
  logic         r_valid, r_last, r_ovf;
  logic [1:0]   r_idx;
  logic [W-1:0] r_data [4][2];

  fft_16_4_out_serializer #(.OUTPUT_WIDTH(W), .BIT_REVERSE(1'b0)) u_nat (
    .clk(clk), .rst_sync(rst_sync), .i_valid(i_valid), .i_data(i_data),
    .o_valid(n_valid), .o_ready(o_ready), .o_data(n_data), .o_beat_idx(n_idx),
    .o_last(n_last), .o_overflow(n_ovf), .clr_overflow(clr_overflow));

  fft_16_4_out_serializer #(.OUTPUT_WIDTH(W), .BIT_REVERSE(1'b1)) u_rev (
    .clk(clk), .rst_sync(rst_sync), .i_valid(i_valid), .i_data(i_data),
    .o_valid(r_valid), .o_ready(o_ready), .o_data(r_data), .o_beat_idx(r_idx),
    .o_last(r_last), .o_overflow(r_ovf), .clr_overflow(clr_overflow));

  logic [127:0] n_flat, r_flat;
  always_comb begin
    n_flat = '0;
    r_flat = '0;
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 2; c++) begin
        n_flat[(l*2+c)*16 +: 16] = n_data[l][c];
        r_flat[(l*2+c)*16 +: 16] = r_data[l][c];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame store indexed by frame id; the model queue holds ids.
  logic [W-1:0] fmem [512][16][2];
  int next_id = 0;

  task automatic make_frame(input bit ramp, output int id);
    id = next_id;
    next_id++;
    for (int k = 0; k < 16; k++) begin
      fmem[id % 512][k][0] = ramp ? W'(k)  : W'($urandom);
      fmem[id % 512][k][1] = ramp ? W'(-k) : W'($urandom);
    end
  endtask

  function automatic int bitrev(input int j);
    return ((j & 1) << 3) | ((j & 2) << 1) | ((j & 4) >> 1) | ((j & 8) >> 3);
  endfunction

  function automatic logic [127:0] exp_beat(input int id, input int beat, input bit br);
    logic [127:0] f;
    int src;
    f = '0;
    for (int l = 0; l < 4; l++) begin
      src = br ? bitrev(4*beat + l) : 4*beat + l;
      f[l*32 +: 16]      = fmem[id % 512][src][0];
      f[l*32 + 16 +: 16] = fmem[id % 512][src][1];
    end
    return f;
  endfunction

  // Reference model: FIFO of at most two frames, head is the one being streamed.
  int mq[$];
  int mbeat = 0;
  bit mov   = 1'b0;

  task automatic compare_model();
    bit mv;
    mv = (mq.size() > 0);
    check("nat_valid", n_valid, mv);
    check("rev_valid", r_valid, mv);
    check("nat_idx", n_idx, mbeat);
    check("rev_idx", r_idx, mbeat);
    check("nat_last", n_last, mv && mbeat == 3);
    check("rev_last", r_last, mv && mbeat == 3);
    check("nat_ovf", n_ovf, mov);
    check("rev_ovf", r_ovf, mov);
    if (mv) begin
      check("nat_data", n_flat, exp_beat(mq[0], mbeat, 1'b0));
      check("rev_data", r_flat, exp_beat(mq[0], mbeat, 1'b1));
    end
  endtask

  task automatic cycle(input bit v, input bit rdy, input bit clr, input bit rst, input int id);
    bit fire, eof, drop;
    int room;
    rst_sync     = rst;
    i_valid      = v;
    o_ready      = rdy;
    clr_overflow = clr;
    for (int k = 0; k < 16; k++)
      for (int c = 0; c < 2; c++)
        i_data[k][c] = v ? fmem[id % 512][k][c] : W'($urandom);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mbeat = 0;
      mov   = 1'b0;
    end else begin
      fire = (mq.size() > 0) && rdy;
      eof  = fire && (mbeat == 3);
      room = mq.size() - (eof ? 1 : 0);
      drop = 1'b0;
      if (eof) begin
        void'(mq.pop_front());
        mbeat = 0;
      end else if (fire) begin
        mbeat++;
      end
      if (v) begin
        if (room < 2) mq.push_back(id);
        else          drop = 1'b1;
      end
      if (drop)     mov = 1'b1;
      else if (clr) mov = 1'b0;
    end
    #1;
    compare_model();
  endtask

  typedef struct packed {
    logic            v;
    logic            exp_valid;
    logic [1:0]      exp_idx;
    logic            exp_last;
    logic [3:0][3:0] nat_re;
    logic [3:0][3:0] rev_re;
  } vec_t;

  function automatic logic [127:0] ramp_beat(input logic [3:0][3:0] re);
    logic [127:0] f;
    f = '0;
    for (int l = 0; l < 4; l++) begin
      f[l*32 +: 16]      = W'(re[l]);
      f[l*32 + 16 +: 16] = W'(-int'(re[l]));
    end
    return f;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [5];
    int f0, f1, f2, ramp_id;
    logic [127:0] held;
    int valid_seen;

    // Element [3] is written first in each nibble list.
    tbl[0] = '{1'b1, 1'b1, 2'd0, 1'b0, {4'd3,  4'd2,  4'd1, 4'd0},  {4'd12, 4'd4, 4'd8,  4'd0}};
    tbl[1] = '{1'b0, 1'b1, 2'd1, 1'b0, {4'd7,  4'd6,  4'd5, 4'd4},  {4'd14, 4'd6, 4'd10, 4'd2}};
    tbl[2] = '{1'b0, 1'b1, 2'd2, 1'b0, {4'd11, 4'd10, 4'd9, 4'd8},  {4'd13, 4'd5, 4'd9,  4'd1}};
    tbl[3] = '{1'b0, 1'b1, 2'd3, 1'b1, {4'd15, 4'd14, 4'd13,4'd12}, {4'd15, 4'd7, 4'd11, 4'd3}};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 16'd0};

    // Reset state
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 0);
    check("rst_nat_data", n_flat, '0);
    check("rst_rev_data", r_flat, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Single ramp frame, both orderings
    make_frame(1'b1, ramp_id);
    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].v, 1'b1, 1'b0, 1'b0, ramp_id);
      check("tbl_valid", n_valid, tbl[i].exp_valid);
      check("tbl_idx", r_idx, tbl[i].exp_idx);
      check("tbl_last", r_last, tbl[i].exp_last);
      if (tbl[i].exp_valid) begin
        check("tbl_nat_beat", n_flat, ramp_beat(tbl[i].nat_re));
        check("tbl_rev_beat", r_flat, ramp_beat(tbl[i].rev_re));
      end
    end

    // Backpressure hold during beat 1
    make_frame(1'b0, f0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, f0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    held = r_flat;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("bp_hold_data", r_flat, held);
      check("bp_hold_idx", r_idx, 2'd1);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("bp_resume_idx", r_idx, 2'd2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("bp_done", r_valid, 1'b0);

    // Three back-to-back frames under backpressure: third is dropped
    make_frame(1'b0, f0);
    make_frame(1'b0, f1);
    make_frame(1'b0, f2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, f0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, f1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, f2);
    check("ovf_set", n_ovf, 1'b1);
    valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) check("b2b_f1_first", n_flat, exp_beat(f1, 0, 1'b0));
      if (n_valid) valid_seen++;
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    end
    check("b2b_beats", valid_seen, 8);
    check("b2b_idle", n_valid, 1'b0);
    check("ovf_sticky", r_ovf, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
    check("ovf_clear", r_ovf, 1'b0);

    // New frame coincides with end-of-frame while pending is full
    make_frame(1'b0, f0);
    make_frame(1'b0, f1);
    make_frame(1'b0, f2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, f0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, f1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, f2);
    check("simul_no_ovf", n_ovf, 1'b0);
    check("simul_p_next", r_flat, exp_beat(f1, 0, 1'b1));
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
      if (i == 3) check("simul_new_frame", n_flat, exp_beat(f2, 0, 1'b0));
    end
    check("simul_idle", n_valid, 1'b0);

    // Reset during beat 2 with pending full
    make_frame(1'b0, f0);
    make_frame(1'b0, f1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, f0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, f1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("pre_rst_idx", n_idx, 2'd2);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 0);
    check("rst_mid_valid", n_valid, 1'b0);
    check("rst_mid_idx", r_idx, 2'd0);
    check("rst_mid_nat_data", n_flat, '0);
    check("rst_mid_rev_data", r_flat, '0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
      check("rst_no_beats", r_valid, 1'b0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit v, rdy, clr, rst;
      int id;
      v   = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < 70);
      clr = ($urandom_range(0, 99) < 5);
      rst = ($urandom_range(0, 999) < 8);
      id  = 0;
      if (v) make_frame(1'b0, id);
      cycle(v, rdy, clr, rst, id);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_16_4_out_serializer.md
Name: fft_16_4_out_serializer

Overview:
- Back-end of the 16-point FFT datapath. Accepts one complete 16-point complex result frame in a single cycle, in the same form the FFT core's output interface produces it (o_valid plus o_data[16][2]).
- Emits the frame as four 4-sample beats using a valid/ready handshake, mirroring the FFT's 4-samples-per-cycle input interface.
- Holds a two-frame buffer (active plus pending) to absorb downstream backpressure. Optionally undoes bit-reversed output ordering.

Parameters:
- OUTPUT_WIDTH, 16: bit width of each real or imaginary component, two's complement.
- BIT_REVERSE, 1: 1 = output sample j is taken from input index bitrev4(j); 0 = natural order.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_sync  input  1  synchronous, active-high reset.
- i_valid  input  1  frame strobe from the FFT core; no backpressure path to the core.
- i_data  input  [OUTPUT_WIDTH-1:0] x [16][2]  frame samples; [k][0] = real, [k][1] = imag.
- o_valid  output  1  a beat is presented on o_data.
- o_ready  input  1  downstream accepts the beat.
- o_data  output  [OUTPUT_WIDTH-1:0] x [4][2]  beat samples, same [real, imag] layout.
- o_beat_idx  output  2  index of the current beat within its frame (0..3).
- o_last  output  1  high when o_beat_idx == 3 and o_valid is high.
- o_overflow  output  1  sticky flag: a frame was dropped.
- clr_overflow  input  1  clears o_overflow.

Behaviour:
- Reset: when rst_sync is sampled high, the following all go to 0 on the next edge: o_valid, o_data, o_beat_idx, o_last, o_overflow, both buffer-valid bits and the beat counter.
  - Reset wins over every other input.
  - Reset mid-frame discards the active and pending frames.
- Storage:
  - Active buffer A (valid bit a_v) and pending buffer P (valid bit p_v), each holding 16 x 2 x OUTPUT_WIDTH bits.
  - 2-bit beat counter cnt.
- State machine:
  - IDLE: a_v = 0.
  - STREAM: a_v = 1.
  - o_valid = a_v, registered.
- Beat contents: o_data[l] = A[m(4*cnt + l)] for l = 0..3, where m(j) = bitrev4(j) if BIT_REVERSE, else m(j) = j.
  - Example: with BIT_REVERSE=1, beat 0 carries input indices 0, 8, 4, 12.
  - o_beat_idx = cnt.
- Fire = o_valid && o_ready.
  - While o_valid && !o_ready, o_data, o_beat_idx and o_last hold stable.
  - On fire with cnt < 3: cnt increments.
- On fire with cnt == 3 (end of frame):
  - If p_v: A <= P, p_v <= 0, cnt <= 0. o_valid stays high, so the next frame's beat 0 appears on the next cycle with no bubble.
  - Else: a_v <= 0, returning to IDLE.
- Capture of a frame on i_valid, with "end of frame" as defined above:
  - a_v = 0: load A, cnt = 0. o_valid rises on the next cycle, giving a latency of 1 cycle from i_valid to the first beat.
  - a_v = 1, p_v = 0, no end of frame this cycle: load P.
  - a_v = 1, p_v = 0, end of frame this cycle: load A directly, cnt = 0, no bubble.
  - a_v = 1, p_v = 1, end of frame this cycle: P is promoted to A and the new frame loads P. No drop.
  - a_v = 1, p_v = 1, no end of frame this cycle: the new frame is dropped and o_overflow <= 1. Buffers are unchanged.
- o_overflow:
  - Remains set until clr_overflow or reset.
  - If clr_overflow and a drop occur in the same cycle, set wins.
- Throughput: sustains one frame every 4 cycles with o_ready tied high. Frames arriving faster than that eventually overflow.
- Data is passed through with no arithmetic; widths are preserved exactly.

Test Plan:
- Single frame, natural order: BIT_REVERSE=0, i_data[k] = {k, -k}, o_ready=1.
  - Expect: o_valid high 1 cycle after i_valid, for 4 consecutive cycles.
  - Beat 0 = {0,0},{1,-1},{2,-2},{3,-3}.
  - o_last only on beat 3; then o_valid = 0.
- Bit-reverse order: same frame with BIT_REVERSE=1.
  - Expect beat 0 real parts = 0, 8, 4, 12 and beat 3 real parts = 3, 11, 7, 15.
- Backpressure hold: drop o_ready for 5 cycles during beat 1.
  - Expect o_data and o_beat_idx=1 held constant; resume to beat 2 after o_ready returns.
- Back-to-back and overflow: o_ready=0, apply i_valid frames F0, F1, F2 on 3 consecutive cycles.
  - Expect o_overflow=1 one cycle after F2; F2 never appears.
  - With o_ready=1 afterwards: 8 contiguous beats, F0 then F1, no gap.
  - clr_overflow then clears the flag.
- Simultaneous events: with A and P full, i_valid coincides with the beat-3 fire.
  - Expect no overflow; P streams next, then the new frame.
- Reset mid-operation: assert rst_sync during beat 2 with P full.
  - Expect all outputs 0 on the next cycle and no beats after release until a new i_valid.
